// File: rtl/spi_display_window_if.sv
// Purpose: window request, pixel source and display byte-stream signals of spi_display_window.
// Latency: none, wiring only.
// Backpressure: the byte stream uses get/empty; the pixel source uses pix_get/pix_empty.
interface spi_display_window_if #(
  parameter int W = 9
);
  logic [W-1:0] x0;
  logic [W-1:0] y0;
  logic [W-1:0] x1;
  logic [W-1:0] y1;
  logic         start;
  logic         busy;
  logic         done;
  logic         error;
  logic [7:0]   pix_data;
  logic         pix_empty;
  logic         pix_get;
  logic         dc;
  logic [7:0]   data;
  logic         empty;
  logic         get;

  // Display-controller side (the design)
  modport slave (
    input  x0, y0, x1, y1, start, pix_data, pix_empty, get,
    output busy, done, error, pix_get, dc, data, empty
  );

  // Requester / serializer side
  modport master (
    output x0, y0, x1, y1, start, pix_data, pix_empty, get,
    input  busy, done, error, pix_get, dc, data, empty
  );
endinterface

// File: rtl/spi_display_window.sv
// Purpose: sends the column/row address header for a window, then streams 2 bytes per pixel from the source.
// Latency: the first header byte is offered in the cycle after an accepted start.
// Backpressure: a byte moves only when get=1 and empty=0; in the pixel phase empty follows the source.
module spi_display_window #(
  parameter int W = 9
) (
  input logic                 clock,
  input logic                 reset,
  spi_display_window_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CMD, PIX, FIN} state_t;

  state_t       state_q, state_d;
  logic [3:0]   idx_q, idx_d;
  logic         phase_q, phase_d;
  logic [W-1:0] col_q, col_d;
  logic [W-1:0] row_q, row_d;
  logic [W-1:0] xs_q, xs_d, ys_q, ys_d, xe_q, xe_d, ye_q, ye_d;
  logic         err_q, err_d;

  logic [15:0]  xs16, ys16, xe16, ye16;
  logic         col_last, row_last;
  logic [7:0]   hdr_byte;
  logic         hdr_dc;

  assign xs16 = 16'(xs_q);
  assign ys16 = 16'(ys_q);
  assign xe16 = 16'(xe_q);
  assign ye16 = 16'(ye_q);

  // Counters end at the window extent; latched corners are already validated as ordered
  assign col_last = (col_q == (xe_q - xs_q));
  assign row_last = (row_q == (ye_q - ys_q));

  // Header byte and its command/parameter flag selected by the header index
  always_comb begin
    hdr_byte = 8'h00;
    hdr_dc   = 1'b1;
    case (idx_q)
      4'd0:    begin hdr_byte = 8'h2A; hdr_dc = 1'b0; end
      4'd1:    hdr_byte = xs16[15:8];
      4'd2:    hdr_byte = xs16[7:0];
      4'd3:    hdr_byte = xe16[15:8];
      4'd4:    hdr_byte = xe16[7:0];
      4'd5:    begin hdr_byte = 8'h2B; hdr_dc = 1'b0; end
      4'd6:    hdr_byte = ys16[15:8];
      4'd7:    hdr_byte = ys16[7:0];
      4'd8:    hdr_byte = ye16[15:8];
      4'd9:    hdr_byte = ye16[7:0];
      4'd10:   begin hdr_byte = 8'h2C; hdr_dc = 1'b0; end
      default: hdr_byte = 8'h00;
    endcase
  end

  // Next-state and output decode
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    phase_d = phase_q;
    col_d   = col_q;
    row_d   = row_q;
    xs_d    = xs_q;
    ys_d    = ys_q;
    xe_d    = xe_q;
    ye_d    = ye_q;
    err_d   = err_q;

    bus.busy    = 1'b0;
    bus.done    = 1'b0;
    bus.error   = 1'b0;
    bus.empty   = 1'b1;
    bus.dc      = 1'b0;
    bus.data    = 8'h00;
    bus.pix_get = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          xs_d    = bus.x0;
          ys_d    = bus.y0;
          xe_d    = bus.x1;
          ye_d    = bus.y1;
          idx_d   = 4'd0;
          phase_d = 1'b0;
          col_d   = '0;
          row_d   = '0;
          if ((bus.x0 <= bus.x1) && (bus.y0 <= bus.y1)) begin
            state_d = CMD;
            err_d   = 1'b0;
          end else begin
            state_d = FIN;
            err_d   = 1'b1;
          end
        end
      end
      CMD: begin
        bus.busy  = 1'b1;
        bus.empty = 1'b0;
        bus.dc    = hdr_dc;
        bus.data  = hdr_byte;
        if (bus.get) begin
          if (idx_q == 4'd10) begin
            idx_d   = 4'd0;
            state_d = PIX;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      PIX: begin
        bus.busy    = 1'b1;
        bus.dc      = 1'b1;
        bus.data    = bus.pix_data;
        bus.empty   = bus.pix_empty;
        bus.pix_get = bus.get & ~bus.pix_empty;
        if (bus.get && !bus.pix_empty) begin
          phase_d = ~phase_q;
          // Pixel position advances only after its low byte
          if (phase_q) begin
            if (col_last) begin
              col_d = '0;
              if (row_last) begin
                row_d   = '0;
                state_d = FIN;
              end else begin
                row_d = row_q + W'(1);
              end
            end else begin
              col_d = col_q + W'(1);
            end
          end
        end
      end
      FIN: begin
        bus.done  = 1'b1;
        bus.error = err_q;
        err_d     = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and latched window corners
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      phase_q <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
      xs_q    <= '0;
      ys_q    <= '0;
      xe_q    <= '0;
      ye_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      phase_q <= phase_d;
      col_q   <= col_d;
      row_q   <= row_d;
      xs_q    <= xs_d;
      ys_q    <= ys_d;
      xe_q    <= xe_d;
      ye_q    <= ye_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_spi_display_window.sv
// Purpose: self-checking bench for spi_display_window against a byte-stream reference model.
// Latency: checks first header byte one cycle after start and done one cycle after the last byte.
// Backpressure: drives random get and pix_empty and checks order, count and pix_get legality.
module tb_spi_display_window;
  localparam int W = 9;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  spi_display_window_if #(.W(W)) bus ();

  spi_display_window #(.W(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  logic [7:0] src_mem [0:4095];
  int src_ptr = 0;
  assign bus.pix_data = src_mem[src_ptr[11:0]];

  typedef struct {
    int x0; int y0; int x1; int y1;
    int rnd; int restart_at; int reset_at;
    int exp_err; int exp_pix;
  } vec_t;

  vec_t tbl[$];
  logic [8:0] exp_q[$];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int x0, y0, x1, y1, rnd, restart_at, reset_at, exp_err, exp_pix);
    vec_t v;
    v.x0 = x0; v.y0 = y0; v.x1 = x1; v.y1 = y1;
    v.rnd = rnd; v.restart_at = restart_at; v.reset_at = reset_at;
    v.exp_err = exp_err; v.exp_pix = exp_pix;
    return v;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, " empty"},   bus.empty,   1);
    check({tag, " pix_get"}, bus.pix_get, 0);
    check({tag, " dc"},      bus.dc,      0);
    check({tag, " data"},    bus.data,    0);
    check({tag, " busy"},    bus.busy,    0);
    check({tag, " done"},    bus.done,    0);
    check({tag, " error"},   bus.error,   0);
  endtask

  // Reference: expected {dc,data} stream built from the window rules
  task automatic build_model(input vec_t v, input int start_ptr);
    int npix;
    exp_q.delete();
    if (v.x0 <= v.x1 && v.y0 <= v.y1) begin
      exp_q.push_back({1'b0, 8'h2A});
      exp_q.push_back({1'b1, 8'(v.x0 >> 8)});
      exp_q.push_back({1'b1, 8'(v.x0)});
      exp_q.push_back({1'b1, 8'(v.x1 >> 8)});
      exp_q.push_back({1'b1, 8'(v.x1)});
      exp_q.push_back({1'b0, 8'h2B});
      exp_q.push_back({1'b1, 8'(v.y0 >> 8)});
      exp_q.push_back({1'b1, 8'(v.y0)});
      exp_q.push_back({1'b1, 8'(v.y1 >> 8)});
      exp_q.push_back({1'b1, 8'(v.y1)});
      exp_q.push_back({1'b0, 8'h2C});
      npix = 2 * (v.x1 - v.x0 + 1) * (v.y1 - v.y0 + 1);
      for (int i = 0; i < npix; i++)
        exp_q.push_back({1'b1, src_mem[(start_ptr + i) % 4096]});
    end
  endtask

  task automatic run(input vec_t v, input string tag);
    logic [8:0] got[$];
    int start_ptr, npix, cyc, last_cons, done_cyc, viol;
    bit saw_done, aborted, restarted, pop;
    start_ptr = src_ptr;
    build_model(v, start_ptr);
    npix = 0; last_cons = -1; done_cyc = -1; viol = 0;
    saw_done = 0; aborted = 0; restarted = 0;

    @(negedge clock);
    bus.x0 = W'(v.x0); bus.y0 = W'(v.y0); bus.x1 = W'(v.x1); bus.y1 = W'(v.y1);
    bus.start = 1'b1; bus.get = 1'b0; bus.pix_empty = 1'b0;
    @(negedge clock);

    for (cyc = 0; cyc < 8000; cyc++) begin
      if (v.rnd != 0) begin
        bus.get       = ($urandom_range(0, 3) != 0);
        bus.pix_empty = ($urandom_range(0, 3) == 0);
      end else begin
        bus.get       = 1'b1;
        bus.pix_empty = 1'b0;
      end
      if (v.restart_at >= 0 && npix == v.restart_at && !restarted && got.size() >= 11) begin
        bus.start = 1'b1;
        bus.x0 = '0; bus.y0 = '0; bus.x1 = W'(9); bus.y1 = W'(9);
        restarted = 1;
      end else begin
        bus.start = 1'b0;
      end
      #1;
      if (cyc == 0) begin
        if (v.exp_err != 0) begin
          check({tag, " reject done"}, bus.done, 1);
          check({tag, " reject error"}, bus.error, 1);
          check({tag, " reject busy"}, bus.busy, 0);
        end else begin
          check({tag, " first empty"}, bus.empty, 0);
          check({tag, " first byte"}, bus.data, 8'h2A);
        end
      end
      if (bus.pix_get && bus.pix_empty) viol++;
      if (bus.error && !bus.done) viol++;
      if (bus.busy && v.exp_err != 0) viol++;
      pop = bus.pix_get;
      if (!bus.empty && bus.get) begin
        got.push_back({bus.dc, bus.data});
        last_cons = cyc;
        if (got.size() > 11) begin
          npix++;
          if (!bus.pix_get) viol++;
        end
      end else if (bus.pix_get) begin
        viol++;
      end
      if (bus.done) begin
        saw_done = 1;
        done_cyc = cyc;
        check({tag, " error"}, bus.error, v.exp_err);
        break;
      end
      if (v.reset_at >= 0 && npix == v.reset_at && pop) begin
        @(negedge clock);
        src_ptr += 1;
        reset = 1'b1;
        bus.get = 1'b1;
        #1;
        check_idle_outputs({tag, " in reset"});
        for (int k = 0; k < 2; k++) begin
          @(negedge clock);
          #1;
          check({tag, " reset done"}, bus.done, 0);
        end
        reset = 1'b0;
        aborted = 1;
        break;
      end
      @(negedge clock);
      if (pop) src_ptr += 1;
    end

    check({tag, " pix_get/error/busy rule violations"}, viol, 0);
    if (!aborted) begin
      check({tag, " done seen"}, saw_done, 1);
      check({tag, " byte count"}, got.size(), exp_q.size());
      check({tag, " pixel bytes"}, npix, v.exp_pix);
      for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
        checks++;
        if (got[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL %s stream[%0d]: got 0x%0h, expected 0x%0h", tag, i, got[i], exp_q[i]);
          break;
        end
      end
      if (v.exp_err == 0)
        check({tag, " done latency"}, done_cyc, last_cons + 1);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) src_mem[i] = 8'($urandom);
    reset = 1'b1;
    bus.x0 = '0; bus.y0 = '0; bus.x1 = '0; bus.y1 = '0;
    bus.start = 1'b0; bus.get = 1'b0; bus.pix_empty = 1'b1;

    // x0,y0,x1,y1, rnd, restart_at, reset_at, exp_err, exp_pix
    tbl.push_back(mk(2, 3, 4, 5,       0, -1, -1, 0, 18));
    tbl.push_back(mk(7, 7, 7, 7,       0, -1, -1, 0, 2));
    tbl.push_back(mk(5, 0, 4, 0,       0, -1, -1, 1, 0));
    tbl.push_back(mk(0, 5, 0, 4,       0, -1, -1, 1, 0));
    tbl.push_back(mk(1, 2, 4, 3,       1, -1, -1, 0, 16));
    tbl.push_back(mk(10, 20, 12, 20,   1,  3, -1, 0, 6));
    tbl.push_back(mk(0, 0, 3, 2,       0, -1,  5, 0, 24));
    tbl.push_back(mk(0, 0, 1, 0,       0, -1, -1, 0, 4));
    tbl.push_back(mk(0, 0, 0, 3,       1, -1, -1, 0, 8));
    tbl.push_back(mk(510, 510, 511, 511, 1, -1, -1, 0, 8));
    tbl.push_back(mk(0, 0, 511, 0,     1, -1, -1, 0, 1024));
    for (int i = 0; i < 6; i++) begin
      int a, b, c, d, e;
      a = $urandom_range(0, 7); b = $urandom_range(0, 7);
      c = $urandom_range(0, 7); d = $urandom_range(0, 7);
      e = (a <= c && b <= d) ? 0 : 1;
      tbl.push_back(mk(a, b, c, d, 1, -1, -1, e,
                       (e != 0) ? 0 : 2 * (c - a + 1) * (d - b + 1)));
    end

    repeat (2) @(negedge clock);
    #1;
    check_idle_outputs("reset state");
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_idle_outputs("after reset");

    for (int i = 0; i < tbl.size(); i++) begin
      run(tbl[i], $sformatf("vec%0d", i));
      repeat (2) @(negedge clock);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spi_display_window.md
SPI_DISPLAY_WINDOW -- requirements
Module: spi_display_window

Interface
REQ-001 SHALL have parameter W, default 9, giving the coordinate width in bits (1..16).
REQ-002 SHALL have port clock  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports x0, y0, x1, y1  input  W each  inclusive window corners, sampled only on an accepted start.
REQ-005 SHALL have port start  input  1  one-cycle request to program the window and stream its pixels.
REQ-006 SHALL have port busy  output  1  high from the first cycle after an accepted start until done.
REQ-007 SHALL have port done  output  1  one-cycle pulse at the end of a transfer.
REQ-008 SHALL have port error  output  1  valid with done; high means the window was rejected.
REQ-009 SHALL have ports pix_data  input  8,  pix_empty  input  1,  pix_get  output  1  pixel byte source, two bytes per pixel, high byte first.
REQ-010 SHALL have ports dc  output  1,  data  output  8,  empty  output  1,  get  input  1  byte stream to the SPI display serializer; dc=0 command, dc=1 parameter/pixel.

Function
REQ-011 SHALL use the get/empty handshake: a byte is offered while empty=0 and is consumed at the rising edge where get=1 and empty=0; get while empty=1 SHALL have no effect.
REQ-012 SHALL implement states IDLE, CMD, PIX, FIN.
REQ-013 In IDLE, start=1 SHALL latch x0..y1, and the next state SHALL be CMD when x0<=x1 and y0<=y1, otherwise FIN with error set.
REQ-014 start SHALL be ignored in every state except IDLE.
REQ-015 In CMD the block SHALL emit exactly 11 bytes in order: 0x2A, xs[15:8], xs[7:0], xe[15:8], xe[7:0], 0x2B, ys[15:8], ys[7:0], ye[15:8], ye[7:0], 0x2C.
REQ-016 In the CMD sequence, xs/xe/ys/ye SHALL be the latched x0/x1/y0/y1 zero-extended to 16 bits.
REQ-017 dc SHALL be 0 for 0x2A, 0x2B and 0x2C, and 1 for every other byte.
REQ-018 In CMD, empty SHALL be 0 and a 4-bit index SHALL advance on each consumed byte.
REQ-019 The consume of byte 11 SHALL move the state to PIX.
REQ-020 In PIX, dc SHALL be 1, data SHALL equal pix_data, empty SHALL equal pix_empty, and pix_get SHALL equal get & ~pix_empty.
REQ-021 pix_get SHALL be 0 in all states other than PIX.
REQ-022 PIX SHALL count consumed bytes using a phase bit, a column counter 0..x1-x0 and a row counter 0..y1-y0, each W bits wide, with no multiplier.
REQ-023 The consume of the high byte of the last pixel (column x1-x0, row y1-y0) SHALL still require its low byte before the transfer ends.
REQ-024 The consume of the low byte of the last pixel SHALL move the state to FIN.
REQ-025 The total bytes streamed in PIX SHALL be 2*(x1-x0+1)*(y1-y0+1).
REQ-026 Column wrap SHALL clear the column counter and increment the row counter in the same edge.
REQ-027 FIN SHALL last one cycle with done=1, and the next state SHALL be IDLE.
REQ-028 busy SHALL be 1 in CMD and PIX only.
REQ-029 In IDLE and FIN, empty SHALL be 1, dc SHALL be 0 and data SHALL be 0x00.
REQ-030 Latency: when start is accepted at edge N, the first byte 0x2A SHALL be offered (empty=0) in the cycle following edge N.
REQ-031 A single-pixel window (x0=x1, y0=y1) SHALL stream exactly 2 pixel bytes.
REQ-032 A window with W-bit maximum coordinates SHALL not overflow any counter.
REQ-033 error SHALL be 0 in every cycle except a FIN cycle entered by rejection.

Reset
REQ-034 Asserting reset SHALL immediately force state IDLE, clear all counters and latched coordinates, and clear busy, done and error.
REQ-035 Under reset, empty SHALL be 1, pix_get SHALL be 0, dc SHALL be 0 and data SHALL be 0x00.
REQ-036 Reset during CMD or PIX SHALL abandon the transfer with no done pulse.
REQ-037 After reset the first start SHALL restart the full 11-byte command header.

Verification
REQ-038 Stimulus: start with (x0,y0,x1,y1)=(2,3,4,5), get held at 1, source never empty -> required: bytes 2A,00,02,00,04,2B,00,03,00,05,2C with dc pattern 0,1,1,1,1,0,1,1,1,1,0, then 18 pixel bytes, then done=1 with error=0.
REQ-039 Stimulus: start with (7,7,7,7) -> required: exactly 2 pixel bytes after the header, done on the cycle after the second byte is consumed.
REQ-040 Stimulus: start with x0=5, x1=4 -> required: busy stays 0, no byte offered, done=1 and error=1 one cycle after start.
REQ-041 Stimulus: pix_empty toggled randomly and get toggled randomly -> required: pixel byte order is preserved, no byte is duplicated or dropped, and pix_get is never high while pix_empty=1.
REQ-042 Stimulus: start pulsed again during PIX -> required: it is ignored and the byte count is unchanged.
REQ-043 Stimulus: reset asserted after the 5th pixel byte, then start with (0,0,1,0) -> required: outputs are idle during reset, then a fresh header is sent followed by 4 pixel bytes and done.
